// File: rtl/arith_resize_q.sv
// arith_resize_q: buffered integer width converter with wrap/saturate modes and overflow tracking
module arith_resize_q #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    input  logic [1:0]           a_mode,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data,
    output logic                 result_ovf,
    output logic                 ovf_sticky,
    input  logic                 ovf_clear
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [OUT_WIDTH-1:0] POS_MAX = {OUT_WIDTH{1'b1}} >> 1;
    localparam logic [OUT_WIDTH-1:0] NEG_MIN = ~POS_MAX;
    logic [OUT_WIDTH-1:0] w_data;
    logic                 w_ovf;
    logic [OUT_WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]        r_rd;
    logic [PW-1:0]        r_wr;
    logic [CW-1:0]        r_cnt;
    logic                 r_sticky;
    logic                 w_push;
    logic                 w_pop;
    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_narrow
            logic [IN_WIDTH-OUT_WIDTH-1:0] w_hi;
            logic                          w_uovf;
            logic                          w_sovf;
            assign w_hi   = a_data[IN_WIDTH-1:OUT_WIDTH];
            assign w_uovf = |w_hi;
            assign w_sovf = w_hi != {(IN_WIDTH-OUT_WIDTH){a_data[OUT_WIDTH-1]}};
            assign w_ovf  = a_mode[0] ? w_sovf : w_uovf;
            // wrap modes keep the low bits; saturate modes clamp when the value does not fit
            always_comb begin
                w_data = (a_mode == 2'd2 && w_uovf) ? {OUT_WIDTH{1'b1}} :
                         (a_mode == 2'd3 && w_sovf) ? (a_data[IN_WIDTH-1] ? NEG_MIN : POS_MAX) :
                         a_data[OUT_WIDTH-1:0];
            end
        end else if (OUT_WIDTH > IN_WIDTH) begin : g_wide
            logic w_ext;
            logic w_unused;
            assign w_ext    = a_mode[0] & a_data[IN_WIDTH-1];
            assign w_unused = ^a_mode;
            assign w_ovf    = 1'b0;
            // signed modes sign-extend, unsigned modes zero-extend; every value fits
            always_comb begin
                w_data = {{(OUT_WIDTH-IN_WIDTH){w_ext}}, a_data};
            end
        end else begin : g_same
            logic w_unused;
            assign w_unused = ^a_mode;
            assign w_ovf    = 1'b0;
            // equal widths pass the value through unchanged in every mode
            always_comb begin
                w_data = a_data;
            end
        end
    endgenerate
    assign a_ready                   = r_cnt != CW'(DEPTH);
    assign result_valid              = r_cnt != '0;
    assign w_push                    = a_valid & a_ready;
    assign w_pop                     = result_valid & result_ready;
    assign {result_ovf, result_data} = result_valid ? r_mem[r_rd] : '0;
    assign ovf_sticky                = r_sticky;
    // queue pointers, occupancy and sticky overflow; a same-cycle overflowing push beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd     <= '0;
            r_wr     <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_sticky <= (ovf_clear ? 1'b0 : r_sticky) | (w_push & w_ovf);
        end
    end
    // entry storage needs no reset because an empty queue forces its outputs to zero
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_ovf, w_data};
    end
endmodule

// File: tb/tb_arith_resize_q.sv
// tb_arith_resize_q: scoreboard bench for the narrowing converter plus direct checks of widening
module tb_arith_resize_q;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_data = '0;
    logic [1:0]  a_mode = '0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic [15:0] result_data;
    logic        result_ovf;
    logic        ovf_sticky;
    logic        ovf_clear = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [7:0]  b_data = '0;
    logic [1:0]  b_mode = '0;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    logic        b_rovf;
    logic        b_sticky;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pop_cyc [$];
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    arith_resize_q #(.IN_WIDTH(32), .OUT_WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .a_mode(a_mode), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_ovf(result_ovf), .ovf_sticky(ovf_sticky),
        .ovf_clear(ovf_clear)
    );

    arith_resize_q #(.IN_WIDTH(8), .OUT_WIDTH(16), .DEPTH(2)) dut_wide (
        .clk(clk), .rst(rst), .a_valid(b_valid), .a_ready(b_ready), .a_data(b_data),
        .a_mode(b_mode), .result_valid(b_rvalid), .result_ready(1'b1),
        .result_data(b_rdata), .result_ovf(b_rovf), .ovf_sticky(b_sticky),
        .ovf_clear(1'b0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [31:0] a, input logic [1:0] m);
        logic uo;
        logic so;
        uo = a > 32'h0000_FFFF;
        so = ($signed(a) > 32'sd32767) || ($signed(a) < -32'sd32768);
        case (m)
            2'd0:    model = {uo, a[15:0]};
            2'd1:    model = {so, a[15:0]};
            2'd2:    model = uo ? {1'b1, 16'hFFFF} : {1'b0, a[15:0]};
            default: model = so ? ($signed(a) < 0 ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF}) : {1'b0, a[15:0]};
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) sb.delete();
        else if (result_valid && result_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) check_eq("pop_unexpected", 32'(result_data), 32'hDEAD);
            else begin
                e = sb.pop_front();
                check_eq("result_data", 32'(result_data), 32'(e[15:0]));
                check_eq("result_ovf", 32'(result_ovf), 32'(e[16]));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [16:0] exp, input logic clr);
        int t = 0;
        a_valid = 1'b1;
        a_data = d;
        a_mode = m;
        ovf_clear = clr;
        @(negedge clk);
        while (!a_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!a_ready) check_eq("send_timeout", 32'(a_ready), 32'd1);
        else sb.push_back(exp);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        ovf_clear = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || result_valid) && t < 100) begin
            t++;
            @(negedge clk);
        end
        check_eq("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wsend(input logic [1:0] m, input logic [15:0] exp);
        b_valid = 1'b1;
        b_data = 8'h80;
        b_mode = m;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(negedge clk);
        check_eq("wide_valid", 32'(b_rvalid), 32'd1);
        check_eq("wide_data", 32'(b_rdata), 32'(exp));
        check_eq("wide_ovf", 32'(b_rovf), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  m;
        int          k;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_data", 32'(result_data), 32'd0);
        check_eq("rst_ovf", 32'(result_ovf), 32'd0);
        check_eq("rst_sticky", 32'(ovf_sticky), 32'd0);
        check_eq("rst_ready", 32'(a_ready), 32'd1);
        check_eq("model_sanity", 32'(model(32'h8000_0000, 2'd3)), 32'h1_8000);
        @(posedge clk);
        #1;
        send(32'h0001_8000, 2'd0, {1'b1, 16'h8000}, 1'b0);
        send(32'h0001_8000, 2'd1, {1'b1, 16'h8000}, 1'b0);
        send(32'h0001_8000, 2'd2, {1'b1, 16'hFFFF}, 1'b0);
        send(32'h0001_8000, 2'd3, {1'b1, 16'h7FFF}, 1'b0);
        send(32'hFFFF_8000, 2'd1, {1'b0, 16'h8000}, 1'b0);
        send(32'hFFFF_8000, 2'd3, {1'b0, 16'h8000}, 1'b0);
        send(32'h8000_0000, 2'd3, {1'b1, 16'h8000}, 1'b0);
        send(32'h0000_1234, 2'd2, {1'b0, 16'h1234}, 1'b0);
        send(32'h0000_7FFF, 2'd3, {1'b0, 16'h7FFF}, 1'b0);
        send(32'h0000_FFFF, 2'd2, {1'b0, 16'hFFFF}, 1'b0);
        drain();
        wsend(2'd0, 16'h0080);
        wsend(2'd1, 16'hFF80);
        wsend(2'd2, 16'h0080);
        wsend(2'd3, 16'hFF80);
        result_ready = 1'b0;
        send(32'h11, 2'd0, {1'b0, 16'h0011}, 1'b0);
        send(32'h22, 2'd0, {1'b0, 16'h0022}, 1'b0);
        @(negedge clk);
        check_eq("bp_full_ready", 32'(a_ready), 32'd0);
        check_eq("bp_hold_data", 32'(result_data), 32'h11);
        @(posedge clk);
        #1;
        check_eq("bp_hold_data2", 32'(result_data), 32'h11);
        result_ready = 1'b1;
        a_valid = 1'b1;
        a_data = 32'h33;
        a_mode = 2'd0;
        @(negedge clk);
        check_eq("bp_pop_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        check_eq("bp_after_pop_ready", 32'(a_ready), 32'd1);
        sb.push_back({1'b0, 16'h0033});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        drain();
        k = pop_cyc.size();
        for (int i = 0; i < 20; i++) begin
            d = (i % 3 == 0) ? $urandom() : $urandom_range(0, 32'h0001_FFFF);
            m = 2'(i % 4);
            send(d, m, model(d, m), 1'b0);
        end
        drain();
        check_eq("stream_count", 32'(pop_cyc.size() - k), 32'd20);
        if (pop_cyc.size() >= k + 20) check_eq("stream_span", 32'(pop_cyc[k+19] - pop_cyc[k]), 32'd19);
        else check_eq("stream_span", 32'(pop_cyc.size() - k), 32'd20);
        send(32'h0002_0000, 2'd0, {1'b1, 16'h0000}, 1'b0);
        check_eq("sticky_set", 32'(ovf_sticky), 32'd1);
        send(32'h0000_0005, 2'd0, {1'b0, 16'h0005}, 1'b1);
        check_eq("sticky_cleared", 32'(ovf_sticky), 32'd0);
        send(32'h0002_0000, 2'd2, {1'b1, 16'hFFFF}, 1'b1);
        check_eq("sticky_clear_ovf", 32'(ovf_sticky), 32'd1);
        drain();
        result_ready = 1'b0;
        send(32'h0001_0000, 2'd0, {1'b1, 16'h0000}, 1'b0);
        send(32'h44, 2'd0, {1'b0, 16'h0044}, 1'b0);
        check_eq("mid_full", 32'(result_valid), 32'd1);
        check_eq("mid_sticky", 32'(ovf_sticky), 32'd1);
        rst = 1'b1;
        a_valid = 1'b1;
        a_data = 32'h0003_0000;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(result_valid), 32'd0);
        check_eq("mid_rst_data", 32'(result_data), 32'd0);
        check_eq("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
        check_eq("mid_rst_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        send(32'h55, 2'd1, {1'b0, 16'h0055}, 1'b0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
